// File: rtl/b01.sv
// ============================================================================
//  Module   : b01
//  Purpose  : Serial adder for back-to-back 4-bit words, LSB first. It flags
//             the carry out of bit 3 on overflw alongside bit 0 of the next word.
//  Option   : B01_STATE_PORT_EN adds the state_dbg output (current FSM code)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module b01 (
  input  logic       clock,
  input  logic       reset,
  input  logic       line1,
  input  logic       line2,
  output logic       outp,
`ifdef B01_STATE_PORT_EN
  output logic       overflw,
  output logic [2:0] state_dbg
`else
  output logic       overflw
`endif
);

  // The state encodes both the bit position within the word and the carry.
  typedef enum logic [2:0] {
    S_A   = 3'd0,
    S_B   = 3'd1,
    S_C   = 3'd2,
    S_E   = 3'd3,
    S_F   = 3'd4,
    S_G   = 3'd5,
    S_WF0 = 3'd6,
    S_WF1 = 3'd7
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_outp;
  logic   r_ovf;
  logic   w_outp_nxt;
  logic   w_ovf_nxt;
  logic   w_and;
  logic   w_or;
  logic   w_xor;

  assign w_and = line1 & line2;
  assign w_or  = line1 | line2;
  assign w_xor = line1 ^ line2;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_A;
      r_outp  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_outp  <= w_outp_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = S_A;
    w_outp_nxt  = w_xor;
    w_ovf_nxt   = 1'b0;
    unique case (r_state)
      S_A:   w_state_nxt = w_and ? S_F : S_B;
      S_E: begin
        w_state_nxt = w_and ? S_F : S_B;
        w_ovf_nxt   = 1'b1;
      end
      S_B:   w_state_nxt = w_and ? S_G : S_C;
      S_C:   w_state_nxt = w_and ? S_WF1 : S_WF0;
      S_WF0: w_state_nxt = w_and ? S_E : S_A;
      // Carry-set states: the sum bit is the inverted XOR.
      S_F: begin
        w_state_nxt = w_or ? S_G : S_C;
        w_outp_nxt  = ~w_xor;
      end
      S_G: begin
        w_state_nxt = w_or ? S_WF1 : S_WF0;
        w_outp_nxt  = ~w_xor;
      end
      S_WF1: begin
        w_state_nxt = w_or ? S_E : S_A;
        w_outp_nxt  = ~w_xor;
      end
      default: w_state_nxt = S_A;
    endcase
  end

  assign outp    = r_outp;
  assign overflw = r_ovf;

`ifdef B01_STATE_PORT_EN
  assign state_dbg = r_state;
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_b01.sv
// ============================================================================
//  Module   : tb_b01
//  Purpose  : Scoreboard bench for b01 using directed vectors with
//             hand-computed expectations.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_b01;

  logic       clock;
  logic       reset;
  logic       line1;
  logic       line2;
  logic       outp;
  logic       overflw;
`ifdef B01_STATE_PORT_EN
  logic [2:0] state_dbg;
`endif

  typedef struct {
    logic       o;
    logic       v;
    logic [2:0] s;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  b01 dut (
    .clock   (clock),
    .reset   (reset),
    .line1   (line1),
    .line2   (line2),
    .outp    (outp),
`ifdef B01_STATE_PORT_EN
    .overflw (overflw),
    .state_dbg(state_dbg)
`else
    .overflw (overflw)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one bit on the falling edge and queue what the next rising edge must produce.
  task automatic apply(input logic rst, input logic l1, input logic l2,
                       input logic eo, input logic ev, input logic [2:0] es,
                       input string nm);
    exp_t e;
    @(negedge clock);
    reset = rst;
    line1 = l1;
    line2 = l2;
    e.o = eo; e.v = ev; e.s = es; e.name = nm;
    q.push_back(e);
  endtask

  // Monitor: one expectation per rising edge, sampled just after it.
  initial begin
    exp_t e;
    logic bad;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        bad = (outp !== e.o) || (overflw !== e.v);
`ifdef B01_STATE_PORT_EN
        bad = bad || (state_dbg !== e.s);
        if (bad) begin
          n_errors++;
          $display("FAIL %s: got outp=%b overflw=%b state=%0d, expected outp=%b overflw=%b state=%0d",
                   e.name, outp, overflw, state_dbg, e.o, e.v, e.s);
        end
`else
        if (bad) begin
          n_errors++;
          $display("FAIL %s: got outp=%b overflw=%b, expected outp=%b overflw=%b",
                   e.name, outp, overflw, e.o, e.v);
        end
`endif
      end
    end
  end

  initial begin
    reset = 1'b1;
    line1 = 1'b0;
    line2 = 1'b0;

    // Reset, including with both lines high
    apply(1, 1, 1, 0, 0, 0, "reset_l11");
    apply(1, 0, 1, 0, 0, 0, "reset_l01");

    // 1111 + 0000
    apply(0, 1, 0, 1, 0, 1, "f_b0");
    apply(0, 1, 0, 1, 0, 2, "f_b1");
    apply(0, 1, 0, 1, 0, 6, "f_b2");
    apply(0, 1, 0, 1, 0, 0, "f_b3");

    // 1111 + 1111 continuously
    apply(0, 1, 1, 0, 0, 4, "ff_b0");
    apply(0, 1, 1, 1, 0, 5, "ff_b1");
    apply(0, 1, 1, 1, 0, 7, "ff_b2");
    apply(0, 1, 1, 1, 0, 3, "ff_b3");
    apply(0, 1, 1, 0, 1, 4, "ff_ovf");
    apply(0, 1, 1, 1, 0, 5, "ff_ovf_clear");
    apply(1, 0, 0, 0, 0, 0, "reset_from_g");

    // 0001 + 0001
    apply(0, 1, 1, 0, 0, 4, "one_b0");
    apply(0, 0, 0, 1, 0, 2, "one_b1");
    apply(0, 0, 0, 0, 0, 6, "one_b2");
    apply(0, 0, 0, 0, 0, 0, "one_b3");

    // All zeros
    apply(0, 0, 0, 0, 0, 1, "zero_0");
    apply(0, 0, 0, 0, 0, 2, "zero_1");
    apply(0, 0, 0, 0, 0, 6, "zero_2");
    apply(0, 0, 0, 0, 0, 0, "zero_3");
    apply(0, 0, 0, 0, 0, 1, "zero_4");
    apply(0, 0, 0, 0, 0, 2, "zero_5");
    apply(0, 0, 0, 0, 0, 6, "zero_6");
    apply(0, 0, 0, 0, 0, 0, "zero_7");

    // 1000 + 1000: overflow with zero sum; the carry must not leak into the next word
    apply(0, 0, 0, 0, 0, 1, "msb_b0");
    apply(0, 0, 0, 0, 0, 2, "msb_b1");
    apply(0, 0, 0, 0, 0, 6, "msb_b2");
    apply(0, 1, 1, 0, 0, 3, "msb_b3");
    apply(0, 0, 0, 0, 1, 1, "msb_next_b0");
    apply(0, 0, 0, 0, 0, 2, "msb_next_b1");
    apply(0, 0, 0, 0, 0, 6, "msb_next_b2");
    apply(0, 0, 0, 0, 0, 0, "msb_next_b3");

    // Reset while in F, then 0110 + 0011 = 1001
    apply(0, 1, 1, 0, 0, 4, "midreset_b0");
    apply(1, 1, 1, 0, 0, 0, "midreset");
    apply(0, 0, 1, 1, 0, 1, "post_b0");
    apply(0, 1, 1, 0, 0, 5, "post_b1");
    apply(0, 1, 0, 0, 0, 7, "post_b2");
    apply(0, 0, 0, 1, 0, 0, "post_b3");
    apply(0, 0, 0, 0, 0, 1, "post_next_b0");

    // Let the monitor drain; a leftover expectation is a failure
    repeat (3) @(negedge clock);
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
